// File: rtl/setup_menu_param.sv
// Keypad-driven setup menu: loads the lock configuration, lets the user edit it item by item,
// then either commits the working copy to the *_new outputs or cancels the session.
module setup_menu_param #(
  parameter int unsigned N_PINS     = 4,
  parameter int unsigned PIN_DIGITS = 4,
  parameter int unsigned TIME_W     = 7,
  parameter int unsigned TIME_MIN   = 5,
  parameter int unsigned TIME_MAX   = 60
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           key_valid,
  input  logic [3:0]                     key_code,
  input  logic                           setup_on,
  output logic                           setup_end,
  output logic                           setup_saved,
  output logic [23:0]                    bcd_out,
  output logic                           bcd_enable,
  input  logic                           bip_status_old,
  output logic                           bip_status_new,
  input  logic [TIME_W-1:0]              bip_time_old,
  output logic [TIME_W-1:0]              bip_time_new,
  input  logic [TIME_W-1:0]              lock_time_old,
  output logic [TIME_W-1:0]              lock_time_new,
  input  logic [N_PINS-1:0]              pin_status_old,
  output logic [N_PINS-1:0]              pin_status_new,
  input  logic [N_PINS*PIN_DIGITS*4-1:0] pin_digits_old,
  output logic [N_PINS*PIN_DIGITS*4-1:0] pin_digits_new
);
  localparam int unsigned PW       = PIN_DIGITS * 4;
  localparam int unsigned DW       = N_PINS * PW;
  localparam logic [4:0]  LastItem = 5'(2 * N_PINS + 2);
  localparam logic [7:0]  TimeMin  = 8'(TIME_MIN);
  localparam logic [7:0]  TimeMax  = 8'(TIME_MAX);

  typedef enum logic [2:0] {StIdle, StLoad, StEdit, StCommit, StCancel, StWaitOff} state_e;
  typedef enum logic [1:0] {ItBipEn, ItTime, ItPinEn, ItPinDig} item_e;

  function automatic item_e item_kind(input logic [4:0] it);
    if (it == 5'd1) return ItBipEn;
    if (it <= 5'd3) return ItTime;
    return it[0] ? ItPinEn : ItPinDig;
  endfunction

  // Items 4/5/6/7... map to PIN indices 0/1/1/2...
  function automatic int unsigned item_idx(input logic [4:0] it);
    return (32'(it) - 32'd3) >> 1;
  endfunction

  function automatic logic [7:0] to_bcd2(input logic [TIME_W-1:0] v);
    logic [7:0] v8;
    v8 = 8'(v);
    return {4'((v8 / 8'd10) % 8'd10), 4'(v8 % 8'd10)};
  endfunction

  state_e              state_q, state_d;
  item_e               kind_q, kind_d;
  int unsigned         idx_q, idx_d;
  logic [4:0]          item_q, item_d;
  logic                bip_en_q, bip_en_d;
  logic [TIME_W-1:0]   bip_time_q, bip_time_d, lock_time_q, lock_time_d;
  logic [N_PINS-1:0]   pin_en_q, pin_en_d;
  logic [DW-1:0]       pin_q, pin_d;
  logic [3:0]          tens_q, tens_d, units_q, units_d;
  logic [23:0]         bcd_d;
  logic                bcd_en_d, end_d, saved_d;
  logic [7:0]          time_raw, time_clamped;
  logic [PW-1:0]       pin_sel;
  logic                pin_bit;
  logic [15:0]         value;

  always_comb begin
    state_d     = state_q;
    item_d      = item_q;
    bip_en_d    = bip_en_q;
    bip_time_d  = bip_time_q;
    lock_time_d = lock_time_q;
    pin_en_d    = pin_en_q;
    pin_d       = pin_q;
    tens_d      = tens_q;
    units_d     = units_q;
    end_d       = setup_end;
    saved_d     = setup_saved;
    kind_q      = item_kind(item_q);
    idx_q       = item_idx(item_q);
    time_raw    = 8'(units_q) * 8'd10 + 8'(key_code);
    if (time_raw < TimeMin)      time_clamped = TimeMin;
    else if (time_raw > TimeMax) time_clamped = TimeMax;
    else                         time_clamped = time_raw;

    unique case (state_q)
      StIdle, StLoad: begin
        // Tracking the old config while idle makes the first displayed frame already valid.
        item_d      = 5'd1;
        bip_en_d    = bip_status_old;
        bip_time_d  = bip_time_old;
        lock_time_d = lock_time_old;
        pin_en_d    = pin_status_old;
        pin_en_d[0] = 1'b1;
        pin_d       = pin_digits_old;
        if (state_q == StIdle) begin
          if (setup_on) state_d = StLoad;
        end else begin
          state_d = setup_on ? StEdit : StIdle;
        end
      end
      StEdit: begin
        if (!setup_on) begin
          state_d = StIdle;
        end else if (key_valid) begin
          if (key_code == 4'hE) begin
            state_d = StCancel;
          end else if (key_code == 4'hF) begin
            if (item_q == LastItem) begin
              state_d = StCommit;
            end else begin
              item_d = item_q + 5'd1;
              {tens_d, units_d} = to_bcd2((item_q == 5'd1) ? bip_time_q : lock_time_q);
            end
          end else if (key_code <= 4'd9) begin
            unique case (kind_q)
              ItBipEn: if (key_code <= 4'd1) bip_en_d = key_code[0];
              ItTime: begin
                tens_d  = units_q;
                units_d = key_code;
                if (item_q == 5'd2) bip_time_d = TIME_W'(time_clamped);
                else                lock_time_d = TIME_W'(time_clamped);
              end
              ItPinEn: begin
                for (int unsigned k = 0; k < N_PINS; k++) begin
                  if (k == idx_q && key_code <= 4'd1) pin_en_d[k] = key_code[0];
                end
              end
              ItPinDig: begin
                for (int unsigned k = 0; k < N_PINS; k++) begin
                  if (k == idx_q) pin_d[k*PW +: PW] = PW'({pin_q[k*PW +: PW], key_code});
                end
              end
              default: ;
            endcase
          end
        end
      end
      StCommit, StCancel: state_d = StWaitOff;
      StWaitOff: if (!setup_on) state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (state_d == StCommit) begin
      end_d   = 1'b0;
      saved_d = 1'b1;
    end else if (state_d == StCancel) begin
      end_d   = 1'b0;
      saved_d = 1'b0;
    end else if (state_d == StIdle) begin
      end_d = 1'b1;
    end
  end

  // Display frame is built from next-state values so bcd_out lands one cycle after the key.
  always_comb begin
    kind_d  = item_kind(item_d);
    idx_d   = item_idx(item_d);
    pin_sel = '0;
    pin_bit = 1'b0;
    for (int unsigned k = 0; k < N_PINS; k++) begin
      if (k == idx_d) begin
        pin_sel = pin_d[k*PW +: PW];
        pin_bit = pin_en_d[k];
      end
    end
    value = 16'hFFFF;
    unique case (kind_d)
      ItBipEn:  value[3:0] = {3'b000, bip_en_d};
      ItPinEn:  value[3:0] = {3'b000, pin_bit};
      ItTime:   value[7:0] = {tens_d, units_d};
      ItPinDig: begin
        for (int unsigned j = 0; j < PIN_DIGITS; j++) value[j*4 +: 4] = pin_sel[j*4 +: 4];
      end
      default: ;
    endcase
    bcd_en_d = (state_d == StLoad) || (state_d == StEdit);
    bcd_d    = 24'hFFFFFF;
    if (bcd_en_d) begin
      bcd_d = {(item_d >= 5'd10) ? 4'd1 : 4'd0,
               (item_d >= 5'd10) ? 4'(item_d - 5'd10) : item_d[3:0], value};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      item_q         <= 5'd1;
      bip_en_q       <= 1'b0;
      bip_time_q     <= '0;
      lock_time_q    <= '0;
      pin_en_q       <= '0;
      pin_q          <= '0;
      tens_q         <= '0;
      units_q        <= '0;
      bcd_out        <= 24'hFFFFFF;
      bcd_enable     <= 1'b0;
      setup_end      <= 1'b1;
      setup_saved    <= 1'b0;
      bip_status_new <= 1'b0;
      bip_time_new   <= '0;
      lock_time_new  <= '0;
      pin_status_new <= '0;
      pin_digits_new <= '0;
    end else begin
      state_q     <= state_d;
      item_q      <= item_d;
      bip_en_q    <= bip_en_d;
      bip_time_q  <= bip_time_d;
      lock_time_q <= lock_time_d;
      pin_en_q    <= pin_en_d;
      pin_q       <= pin_d;
      tens_q      <= tens_d;
      units_q     <= units_d;
      bcd_out     <= bcd_d;
      bcd_enable  <= bcd_en_d;
      setup_end   <= end_d;
      setup_saved <= saved_d;
      if (state_d == StCommit) begin
        bip_status_new <= bip_en_q;
        bip_time_new   <= bip_time_q;
        lock_time_new  <= lock_time_q;
        pin_status_new <= pin_en_q;
        pin_digits_new <= pin_q;
      end
    end
  end

endmodule

// File: tb/tb_setup_menu_param.sv
// Directed bench for setup_menu_param: a default instance and a 2-PIN / 3-digit instance,
// with expected values queued in a scoreboard and popped when the DUT output is sampled.
module tb_setup_menu_param;
  localparam int unsigned TW = 7;
  localparam logic [3:0] KNext   = 4'hF;
  localparam logic [3:0] KCancel = 4'hE;

  logic clk = 1'b0;
  logic rst, key_valid, setup_on, setup_on_b;
  logic [3:0] key_code;

  logic          bip_st_old  = 1'b1;
  logic [TW-1:0] bip_t_old   = 7'd30;
  logic [TW-1:0] lock_t_old  = 7'd20;
  logic [3:0]    pin_st_old_a = 4'b0011;
  logic [63:0]   pin_old_a   = 64'h3456_9012_5678_1234;
  logic [1:0]    pin_st_old_b = 2'b11;
  logic [23:0]   pin_old_b   = 24'h789123;

  logic          end_a, saved_a, bcd_en_a, bip_st_new_a;
  logic [23:0]   bcd_a;
  logic [TW-1:0] bip_t_new_a, lock_t_new_a;
  logic [3:0]    pin_st_new_a;
  logic [63:0]   pin_new_a;

  logic          end_b, saved_b, bcd_en_b, bip_st_new_b;
  logic [23:0]   bcd_b;
  logic [TW-1:0] bip_t_new_b, lock_t_new_b;
  logic [1:0]    pin_st_new_b;
  logic [23:0]   pin_new_b;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;
  exp_t sb[$];

  setup_menu_param dut_a (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code), .setup_on(setup_on),
    .setup_end(end_a), .setup_saved(saved_a), .bcd_out(bcd_a), .bcd_enable(bcd_en_a),
    .bip_status_old(bip_st_old), .bip_status_new(bip_st_new_a),
    .bip_time_old(bip_t_old), .bip_time_new(bip_t_new_a),
    .lock_time_old(lock_t_old), .lock_time_new(lock_t_new_a),
    .pin_status_old(pin_st_old_a), .pin_status_new(pin_st_new_a),
    .pin_digits_old(pin_old_a), .pin_digits_new(pin_new_a)
  );

  setup_menu_param #(.N_PINS(2), .PIN_DIGITS(3)) dut_b (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code), .setup_on(setup_on_b),
    .setup_end(end_b), .setup_saved(saved_b), .bcd_out(bcd_b), .bcd_enable(bcd_en_b),
    .bip_status_old(bip_st_old), .bip_status_new(bip_st_new_b),
    .bip_time_old(bip_t_old), .bip_time_new(bip_t_new_b),
    .lock_time_old(lock_t_old), .lock_time_new(lock_t_new_b),
    .pin_status_old(pin_st_old_b), .pin_status_new(pin_st_new_b),
    .pin_digits_old(pin_old_b), .pin_digits_new(pin_new_b)
  );

  always #5 clk = ~clk;

  task automatic expect_val(input string tag, input logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [63:0] obs);
    exp_t e;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %0h, required a queued expectation", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic press(input logic [3:0] k);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = k;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic start_a();
    @(negedge clk);
    setup_on = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic finish_session(input string tag);
    @(negedge clk);
    setup_on = 1'b0;
    @(negedge clk);
    expect_val(tag, 64'd1);
    check(64'(end_a));
  endtask

  initial begin
    rst = 1'b1; key_valid = 1'b0; key_code = 4'h0; setup_on = 1'b0; setup_on_b = 1'b0;
    repeat (2) @(negedge clk);
    expect_val("rst_end", 64'd1);         check(64'(end_a));
    expect_val("rst_saved", 64'd0);       check(64'(saved_a));
    expect_val("rst_bcd_en", 64'd0);      check(64'(bcd_en_a));
    expect_val("rst_bcd", 64'hFFFFFF);    check(64'(bcd_a));
    expect_val("rst_bip_time", 64'd0);    check(64'(bip_t_new_a));
    expect_val("rst_pins", 64'd0);        check(pin_new_a);
    rst = 1'b0;
    @(negedge clk);

    // Beep time edit: 30 -> keys 0,7 -> 7
    start_a();
    expect_val("s1_item1", 64'h01FFF1);   check(64'(bcd_a));
    expect_val("s1_bcd_en", 64'd1);       check(64'(bcd_en_a));
    expect_val("s1_item2", 64'h02FF30);   press(KNext); check(64'(bcd_a));
    expect_val("s1_key0", 64'h02FF00);    press(4'd0);  check(64'(bcd_a));
    expect_val("s1_key7", 64'h02FF07);    press(4'd7);  check(64'(bcd_a));
    repeat (8) press(KNext);
    expect_val("s1_item10", 64'h103456);  check(64'(bcd_a));
    expect_val("s1_end", 64'd0);
    expect_val("s1_saved", 64'd1);
    expect_val("s1_bip_time", 64'd7);
    expect_val("s1_lock_time", 64'd20);
    expect_val("s1_pin_status", 64'b0011);
    expect_val("s1_pins", 64'h3456_9012_5678_1234);
    press(KNext);
    check(64'(end_a)); check(64'(saved_a)); check(64'(bip_t_new_a));
    check(64'(lock_t_new_a)); check(64'(pin_st_new_a)); check(pin_new_a);
    finish_session("s1_end_high");

    // Lock time clamp high: 99 -> 60
    start_a();
    press(KNext);
    expect_val("s2_item3", 64'h03FF20);   press(KNext); check(64'(bcd_a));
    press(4'd9);
    expect_val("s2_key99", 64'h03FF99);   press(4'd9);  check(64'(bcd_a));
    repeat (7) press(KNext);
    expect_val("s2_lock_max", 64'd60);    press(KNext); check(64'(lock_t_new_a));
    finish_session("s2_end_high");

    // Lock time clamp low: 02 -> 5
    start_a();
    repeat (2) press(KNext);
    press(4'd0);
    expect_val("s3_key02", 64'h03FF02);   press(4'd2);  check(64'(bcd_a));
    repeat (7) press(KNext);
    expect_val("s3_lock_min", 64'd5);     press(KNext); check(64'(lock_t_new_a));
    finish_session("s3_end_high");

    // PIN1 digit shift: 1234 -> 3456
    start_a();
    repeat (2) press(KNext);
    expect_val("s4_item4", 64'h041234);   press(KNext); check(64'(bcd_a));
    press(4'd5);
    expect_val("s4_key56", 64'h043456);   press(4'd6);  check(64'(bcd_a));
    repeat (6) press(KNext);
    expect_val("s4_saved", 64'd1);
    expect_val("s4_pins", 64'h3456_9012_5678_3456);
    press(KNext); check(64'(saved_a)); check(pin_new_a);
    finish_session("s4_end_high");

    // Cancel after editing beep enable
    start_a();
    expect_val("s5_edit_en", 64'h01FFF0); press(4'd0);  check(64'(bcd_a));
    expect_val("s5_saved", 64'd0);
    expect_val("s5_end", 64'd0);
    expect_val("s5_bip_status", 64'd1);
    expect_val("s5_bcd_en", 64'd0);
    press(KCancel);
    check(64'(saved_a)); check(64'(end_a)); check(64'(bip_st_new_a)); check(64'(bcd_en_a));
    finish_session("s5_end_high");

    // Abort on item 5 with a simultaneous cancel key
    start_a();
    repeat (3) press(KNext);
    expect_val("s6_item5", 64'h05FFF1);   press(KNext); check(64'(bcd_a));
    expect_val("s6_pin2_off", 64'h05FFF0); press(4'd0); check(64'(bcd_a));
    setup_on = 1'b0; key_valid = 1'b1; key_code = KCancel;
    @(negedge clk);
    key_valid = 1'b0;
    expect_val("s6_abort_end", 64'd1);
    expect_val("s6_abort_bcd_en", 64'd0);
    expect_val("s6_abort_bcd", 64'hFFFFFF);
    expect_val("s6_pin_status", 64'b0011);
    check(64'(end_a)); check(64'(bcd_en_a)); check(64'(bcd_a)); check(64'(pin_st_new_a));
    @(negedge clk);
    expect_val("s6_end_stays", 64'd1);    check(64'(end_a));

    // Two-PIN, three-digit instance: 6 items
    setup_on_b = 1'b1;
    repeat (2) @(negedge clk);
    repeat (4) press(KNext);
    expect_val("b_item6", 64'h06F789);    press(KNext); check(64'(bcd_b));
    expect_val("b_key4", 64'h06F894);     press(4'd4);  check(64'(bcd_b));
    expect_val("b_end", 64'd0);
    expect_val("b_saved", 64'd1);
    expect_val("b_pins", 64'h894123);
    press(KNext); check(64'(end_b)); check(64'(saved_b)); check(64'(pin_new_b));
    @(negedge clk);
    setup_on_b = 1'b0;
    @(negedge clk);
    expect_val("b_end_high", 64'd1);      check(64'(end_b));

    // Asynchronous reset in the middle of an edit
    start_a();
    press(KNext);
    expect_val("r_key3", 64'h02FF03);     press(4'd3);  check(64'(bcd_a));
    rst = 1'b1;
    #1;
    expect_val("r_end", 64'd1);
    expect_val("r_bcd_en", 64'd0);
    expect_val("r_bcd", 64'hFFFFFF);
    expect_val("r_bip_time", 64'd0);
    expect_val("r_lock_time", 64'd0);
    expect_val("r_pins", 64'd0);
    check(64'(end_a)); check(64'(bcd_en_a)); check(64'(bcd_a));
    check(64'(bip_t_new_a)); check(64'(lock_t_new_a)); check(pin_new_a);
    @(negedge clk);
    rst = 1'b0;
    setup_on = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
